// File: rtl/pll_phase_step_ctrl.sv
// pll_phase_step_ctrl
//
// Multi-channel dynamic phase-shift controller for the Cyclone V
// reconfigurable PLL that produces the TDC sampling clocks. A command names
// an output counter, a direction and a step count. The controller then walks
// the PLL phase_en / phase_done handshake one step at a time. It keeps a
// signed, wrapping position for every counter and aborts on lock loss or on a
// step that never completes.
//
// Ports:
//   refclk      sole clock (PLL reference, 50 MHz)
//   rst         asynchronous active-high reset
//   cmd_valid   command request; accepted while cmd_ready is high
//   cmd_ready   high only while idle
//   cmd_ch      target counter index
//   cmd_dir     1 = advance, 0 = retard
//   cmd_steps   number of steps to perform
//   pos_clr     zero all position counters (honoured only while idle)
//   locked      PLL lock, asynchronous
//   phase_done  PLL step-complete, asynchronous
//   phase_en    PLL phase-step enable
//   updn        PLL direction (latched cmd_dir)
//   cntsel      PLL counter select (latched cmd_ch)
//   busy        high whenever a command is in progress
//   done        one-cycle completion pulse
//   err_code    0 ok, 1 not locked / lock lost, 2 timeout, 3 bad channel
//   steps_done  steps completed in the current or last command
//   pos         per-channel signed positions, lane k at [k*POS_W +: POS_W]

module pll_phase_step_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CNTSEL_W  = 5,
    parameter int STEP_W    = 16,
    parameter int POS_W     = 16,
    parameter int EN_CYCLES = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNTSEL_W-1:0]     cmd_ch,
    input  logic                    cmd_dir,
    input  logic [STEP_W-1:0]       cmd_steps,
    input  logic                    pos_clr,
    input  logic                    locked,
    input  logic                    phase_done,
    output logic                    phase_en,
    output logic                    updn,
    output logic [CNTSEL_W-1:0]     cntsel,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err_code,
    output logic [STEP_W-1:0]       steps_done,
    output logic [NUM_CH*POS_W-1:0] pos
);

    localparam int EN_W = $clog2(EN_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PULSE,
        WAIT_LO,
        WAIT_HI,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic                locked_meta;
    logic                locked_sync;
    logic                done_meta;
    logic                done_sync;

    logic [CNTSEL_W-1:0] ch_q;
    logic                dir_q;
    logic [STEP_W-1:0]   steps_q;
    logic [EN_W-1:0]     en_cnt;
    logic [TO_W-1:0]     tmo_cnt;
    logic [POS_W-1:0]    pos_q [NUM_CH];

    logic [1:0]          err_next;
    logic                step_ok;

    // Two-flop synchronisers for the asynchronous PLL status inputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
            done_meta   <= 1'b0;
            done_sync   <= 1'b0;
        end else begin
            locked_meta <= locked;
            locked_sync <= locked_meta;
            done_meta   <= phase_done;
            done_sync   <= done_meta;
        end
    end

    // State register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Lock loss is checked first in every stepping state,
    // so a step that is interrupted never counts. In WAIT_HI, a phase_done
    // seen on the final timeout cycle still completes the step.
    always_comb begin
        state_next = state;
        err_next   = 2'd0;
        step_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (ch_q >= CNTSEL_W'(NUM_CH)) begin
                    state_next = FIN;
                    err_next   = 2'd3;
                end else if (!locked_sync) begin
                    state_next = FIN;
                    err_next   = 2'd1;
                end else if (steps_q == '0) begin
                    state_next = FIN;
                end else begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (!locked_sync) begin
                    state_next = FIN;
                    err_next   = 2'd1;
                end else if (en_cnt == EN_W'(EN_CYCLES - 1)) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!locked_sync) begin
                    state_next = FIN;
                    err_next   = 2'd1;
                end else if (!done_sync) begin
                    state_next = WAIT_HI;
                end else if (tmo_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_next = FIN;
                    err_next   = 2'd2;
                end
            end
            WAIT_HI: begin
                if (!locked_sync) begin
                    state_next = FIN;
                    err_next   = 2'd1;
                end else if (done_sync) begin
                    step_ok = 1'b1;
                    if (steps_done + STEP_W'(1) == steps_q) begin
                        state_next = FIN;
                    end else begin
                        state_next = PULSE;
                    end
                end else if (tmo_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_next = FIN;
                    err_next   = 2'd2;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from state. phase_en is also gated by the synchronised
    // lock, so it falls in the same cycle that lock loss is seen.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == FIN);
        phase_en  = (state == PULSE) && locked_sync;
    end

    // Datapath. The cycle counters restart whenever their state is entered.
    // The same cycle can both accept a command and clear the positions.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            ch_q       <= '0;
            dir_q      <= 1'b0;
            steps_q    <= '0;
            steps_done <= '0;
            err_code   <= 2'd0;
            en_cnt     <= '0;
            tmo_cnt    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                pos_q[k] <= '0;
            end
        end else begin
            if (state == IDLE && cmd_valid) begin
                ch_q       <= cmd_ch;
                dir_q      <= cmd_dir;
                steps_q    <= cmd_steps;
                steps_done <= '0;
                err_code   <= 2'd0;
            end
            if (state != FIN && state_next == FIN) begin
                err_code <= err_next;
            end

            en_cnt  <= (state == PULSE && state_next == PULSE) ? en_cnt + EN_W'(1) : '0;
            tmo_cnt <= ((state == WAIT_LO || state == WAIT_HI) && state_next == state)
                       ? tmo_cnt + TO_W'(1) : '0;

            if (step_ok) begin
                steps_done <= steps_done + STEP_W'(1);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_q == CNTSEL_W'(k)) begin
                        pos_q[k] <= dir_q ? pos_q[k] + POS_W'(1) : pos_q[k] - POS_W'(1);
                    end
                end
            end

            if (state == IDLE && pos_clr) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    pos_q[k] <= '0;
                end
            end
        end
    end

    assign updn   = dir_q;
    assign cntsel = ch_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
        assign pos[g*POS_W +: POS_W] = pos_q[g];
    end

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// tb_pll_phase_step_ctrl
//
// Self-checking bench for pll_phase_step_ctrl. A behavioural PLL answers each
// phase_en pulse. It lowers phase_done one cycle after the pulse starts and
// raises it three cycles later. It can also be told never to raise it.
// Expected results come from a per-command model that applies the step rules
// directly to an array of lane positions.

module tb_pll_phase_step_ctrl;

    localparam int NUM_CH    = 4;
    localparam int CNTSEL_W  = 5;
    localparam int STEP_W    = 16;
    localparam int POS_W     = 16;
    localparam int EN_CYCLES = 2;
    localparam int TIMEOUT   = 1024;
    localparam int BUDGET    = 4000;

    logic                    refclk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CNTSEL_W-1:0]     cmd_ch;
    logic                    cmd_dir;
    logic [STEP_W-1:0]       cmd_steps;
    logic                    pos_clr;
    logic                    locked;
    logic                    phase_done = 1'b1;
    logic                    phase_en;
    logic                    updn;
    logic [CNTSEL_W-1:0]     cntsel;
    logic                    busy;
    logic                    done;
    logic [1:0]              err_code;
    logic [STEP_W-1:0]       steps_done;
    logic [NUM_CH*POS_W-1:0] pos;

    int testCount = 0;
    int failCount = 0;

    logic [POS_W-1:0] expPos [NUM_CH];
    bit               neverRaise = 1'b0;
    int               tick = -1;
    logic             enPrev = 1'b0;

    pll_phase_step_ctrl #(
        .NUM_CH    (NUM_CH),
        .CNTSEL_W  (CNTSEL_W),
        .STEP_W    (STEP_W),
        .POS_W     (POS_W),
        .EN_CYCLES (EN_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .pos_clr    (pos_clr),
        .locked     (locked),
        .phase_done (phase_done),
        .phase_en   (phase_en),
        .updn       (updn),
        .cntsel     (cntsel),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code),
        .steps_done (steps_done),
        .pos        (pos)
    );

    always #10 refclk = ~refclk;

    // Behavioural PLL, driven on the falling edge.
    always @(negedge refclk) begin
        if (rst) begin
            tick       = -1;
            enPrev     = 1'b0;
            phase_done = 1'b1;
        end else begin
            if (phase_en && !enPrev) begin
                tick = 0;
            end else if (tick >= 0) begin
                tick++;
            end
            if (tick == 1) begin
                phase_done = 1'b0;
            end
            if (tick == 4) begin
                tick = -1;
            end
            if (tick < 0 && !neverRaise) begin
                phase_done = 1'b1;
            end
            enPrev = phase_en;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model for a command against a cooperative, locked PLL.
    task automatic modelCommand(input logic [CNTSEL_W-1:0] ch, input logic dir,
                                input logic [STEP_W-1:0] steps, input bit clr,
                                output logic [1:0] expErr, output logic [STEP_W-1:0] expSd,
                                output int expPulses);
        if (clr) begin
            for (int k = 0; k < NUM_CH; k++) expPos[k] = '0;
        end
        if (ch >= NUM_CH) begin
            expErr    = 2'd3;
            expSd     = '0;
            expPulses = 0;
        end else begin
            expErr    = 2'd0;
            expSd     = steps;
            expPulses = int'(steps);
            expPos[ch] = expPos[ch] + (dir ? steps : -steps);
        end
    endtask

    task automatic checkPositions(input string tag);
        for (int k = 0; k < NUM_CH; k++) begin
            checkOutput($sformatf("%s_pos%0d", tag, k), 64'(pos[k*POS_W +: POS_W]), 64'(expPos[k]));
        end
    endtask

    // Issue one command and follow it to done. The cycle count starts at 1
    // on the first falling edge after the accepting clock edge. The locked
    // input drops when phase_en pulse number dropAt starts (0 = never).
    task automatic applyStimulus(input logic [CNTSEL_W-1:0] ch, input logic dir,
                                 input logic [STEP_W-1:0] steps, input bit clr, input int dropAt,
                                 output int pulses, output int doneCyc, output int firstEn,
                                 output logic [1:0] errObs, output logic [STEP_W-1:0] sdObs);
        int cyc;
        int enRun;
        int badHold;
        @(negedge refclk);
        cmd_ch    = ch;
        cmd_dir   = dir;
        cmd_steps = steps;
        pos_clr   = clr;
        cmd_valid = 1'b1;
        checkOutput("ready_before_accept", 64'(cmd_ready), 64'(1));
        @(posedge refclk);
        @(negedge refclk);
        cmd_valid = 1'b0;
        pos_clr   = 1'b0;
        cyc     = 1;
        pulses  = 0;
        doneCyc = -1;
        firstEn = -1;
        enRun   = 0;
        badHold = 0;
        errObs  = 2'd0;
        sdObs   = '0;
        while (cyc <= BUDGET) begin
            if (phase_en) begin
                if (enRun == 0) begin
                    pulses++;
                    if (firstEn < 0) firstEn = cyc;
                    if (pulses == dropAt) locked = 1'b0;
                end
                enRun++;
            end else if (enRun > 0) begin
                checkOutput("en_width", 64'(enRun), 64'(EN_CYCLES));
                enRun = 0;
            end
            if (cntsel !== ch || updn !== dir || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                badHold++;
            end
            if (done === 1'b1) begin
                doneCyc = cyc;
                errObs  = err_code;
                sdObs   = steps_done;
                break;
            end
            @(negedge refclk);
            cyc++;
        end
        checkOutput("done_within_budget", 64'(doneCyc >= 0), 64'(1));
        checkOutput("sel_dir_ready_hold", 64'(badHold), 64'(0));
        if (doneCyc >= 0) begin
            @(negedge refclk);
            checkOutput("after_done_dn_rdy_busy", 64'({done, cmd_ready, busy}), 64'(3'b010));
        end
    endtask

    task automatic runModelled(input string tag, input logic [CNTSEL_W-1:0] ch, input logic dir,
                               input logic [STEP_W-1:0] steps, input bit clr);
        logic [1:0]        expErr;
        logic [STEP_W-1:0] expSd;
        int                expPulses;
        int                pulses, doneCyc, firstEn;
        logic [1:0]        errObs;
        logic [STEP_W-1:0] sdObs;
        modelCommand(ch, dir, steps, clr, expErr, expSd, expPulses);
        applyStimulus(ch, dir, steps, clr, 0, pulses, doneCyc, firstEn, errObs, sdObs);
        checkOutput({tag, "_err"}, 64'(errObs), 64'(expErr));
        checkOutput({tag, "_steps_done"}, 64'(sdObs), 64'(expSd));
        checkOutput({tag, "_pulses"}, 64'(pulses), 64'(expPulses));
        if (expPulses == 0) begin
            checkOutput({tag, "_done_cycle"}, 64'(doneCyc), 64'(2));
        end else begin
            checkOutput({tag, "_first_en"}, 64'(firstEn), 64'(2));
        end
        checkPositions(tag);
    endtask

    initial begin
        int                pulses, doneCyc, firstEn;
        logic [1:0]        errObs;
        logic [STEP_W-1:0] sdObs;
        bit                sawBusy;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        pos_clr   = 1'b0;
        locked    = 1'b1;
        for (int k = 0; k < NUM_CH; k++) expPos[k] = '0;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        repeat (3) @(negedge refclk);

        // Reset state
        checkOutput("rst_ready_busy_en_done", 64'({cmd_ready, busy, phase_en, done}), 64'(4'b1000));
        checkOutput("rst_err_sd", 64'({err_code, steps_done}), 64'(0));
        checkOutput("rst_sel_dir", 64'({cntsel, updn}), 64'(0));
        checkPositions("rst");

        // Directed cases from the test plan
        runModelled("adv5", 5'd2, 1'b1, 16'd5, 1'b0);
        runModelled("ret3", 5'd1, 1'b0, 16'd3, 1'b0);
        checkOutput("ret3_wrap", 64'(pos[1*POS_W +: POS_W]), 64'(16'hFFFD));

        @(negedge refclk);
        pos_clr = 1'b1;
        @(negedge refclk);
        pos_clr = 1'b0;
        for (int k = 0; k < NUM_CH; k++) expPos[k] = '0;
        checkPositions("clr");

        runModelled("zero", 5'd0, 1'b1, 16'd0, 1'b0);
        runModelled("badch", 5'd7, 1'b1, 16'd3, 1'b0);

        // Timeout: PLL never raises phase_done again
        neverRaise = 1'b1;
        applyStimulus(5'd3, 1'b1, 16'd4, 1'b0, 0, pulses, doneCyc, firstEn, errObs, sdObs);
        checkOutput("tmo_err", 64'(errObs), 64'(2));
        checkOutput("tmo_steps_done", 64'(sdObs), 64'(0));
        checkOutput("tmo_pulses", 64'(pulses), 64'(1));
        checkOutput("tmo_late_enough", 64'(doneCyc >= TIMEOUT), 64'(1));
        checkOutput("tmo_not_too_late", 64'(doneCyc <= TIMEOUT + 12), 64'(1));
        checkPositions("tmo");
        neverRaise = 1'b0;
        repeat (4) @(negedge refclk);

        // Lock lost during step 3 of 6
        applyStimulus(5'd0, 1'b1, 16'd6, 1'b0, 3, pulses, doneCyc, firstEn, errObs, sdObs);
        expPos[0] = expPos[0] + 16'd2;
        checkOutput("lock_err", 64'(errObs), 64'(1));
        checkOutput("lock_steps_done", 64'(sdObs), 64'(2));
        checkOutput("lock_pulses", 64'(pulses), 64'(3));
        checkOutput("lock_en_low", 64'(phase_en), 64'(0));
        checkPositions("lock");

        // Not locked at accept
        repeat (4) @(negedge refclk);
        applyStimulus(5'd1, 1'b1, 16'd2, 1'b0, 0, pulses, doneCyc, firstEn, errObs, sdObs);
        checkOutput("nolock_err", 64'(errObs), 64'(1));
        checkOutput("nolock_done_cycle", 64'(doneCyc), 64'(2));
        checkOutput("nolock_pulses", 64'(pulses), 64'(0));
        locked = 1'b1;
        repeat (4) @(negedge refclk);

        // Randomised commands, some with bad channels and simultaneous clear
        for (int i = 0; i < 20; i++) begin
            runModelled($sformatf("rnd%0d", i), CNTSEL_W'($urandom_range(0, 5)),
                        1'($urandom_range(0, 1)), STEP_W'($urandom_range(0, 6)),
                        ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset in the middle of a step
        @(negedge refclk);
        cmd_ch    = 5'd2;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd4;
        cmd_valid = 1'b1;
        @(posedge refclk);
        @(negedge refclk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (phase_done === 1'b0) break;
            @(negedge refclk);
        end
        repeat (4) @(negedge refclk);
        sawBusy = busy;
        checkOutput("midrst_was_busy", 64'(sawBusy), 64'(1));
        #3 rst = 1'b1;
        #1;
        checkOutput("midrst_ready_busy_en_done", 64'({cmd_ready, busy, phase_en, done}), 64'(4'b1000));
        checkOutput("midrst_err_sd_sel_dir", 64'({err_code, steps_done, cntsel, updn}), 64'(0));
        for (int k = 0; k < NUM_CH; k++) expPos[k] = '0;
        checkPositions("midrst");
        @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        repeat (3) @(negedge refclk);
        checkOutput("postrst_no_done", 64'(done), 64'(0));
        runModelled("postrst", 5'd2, 1'b1, 16'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pll_phase_step_ctrl.md
# pll_phase_step_ctrl

Multi-channel dynamic phase-shift controller for the Cyclone V reconfigurable PLL that generates the TDC sampling clocks. It accepts step commands (channel, direction, step count) and drives the PLL `phase_en`/`updn`/`cntsel`/`phase_done` handshake one step at a time. It tracks a signed phase position for every output counter and gates stepping on PLL lock, with per-step timeout. It sits between the HPS/CSR command register and the PLL instance, on the PLL reference clock domain.

## Interface
Parameters:
- `NUM_CH`, 4: number of PLL output counters that can be stepped (1..18).
- `CNTSEL_W`, 5: width of the PLL counter-select bus.
- `STEP_W`, 16: width of the step-count field.
- `POS_W`, 16: width of each signed per-channel position counter.
- `EN_CYCLES`, 2: cycles `phase_en` is held high per step (≥1).
- `TIMEOUT`, 1024: maximum cycles to wait for each `phase_done` edge (≥2).

Ports:
- `refclk`  in  1  sole clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_ch`  in  CNTSEL_W  target counter index.
- `cmd_dir`  in  1  1 = advance (+), 0 = retard (−).
- `cmd_steps`  in  STEP_W  number of steps.
- `pos_clr`  in  1  zero all position counters (IDLE only; ignored otherwise).
- `locked`  in  1  PLL lock, asynchronous; double-flop synchronised internally.
- `phase_done`  in  1  PLL step-complete, asynchronous; double-flop synchronised.
- `phase_en`  out  1  PLL phase-step enable.
- `updn`  out  1  PLL direction, equal to latched `cmd_dir`.
- `cntsel`  out  CNTSEL_W  PLL counter select, equal to latched `cmd_ch`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err_code`  out  2  0 = ok, 1 = not locked or lock lost, 2 = timeout, 3 = bad channel; valid with `done`, held until the next accept.
- `steps_done`  out  STEP_W  steps completed in the current or last command.
- `pos`  out  NUM_CH*POS_W  per-channel signed positions; channel k occupies bits [k*POS_W +: POS_W].

## Operation
- Reset values: `cmd_ready`=1, and all other outputs are 0, including every `pos` lane. The state is IDLE.
- States: IDLE, CHECK, PULSE, WAIT_LO, WAIT_HI, FIN.
- IDLE: accept when `cmd_valid`&`cmd_ready`. On accept, latch ch/dir/steps, clear `steps_done` and `err_code`, then go to CHECK.
- CHECK, evaluated in this priority order:
  - `cmd_ch`≥NUM_CH → FIN with err 3.
  - Synchronised `locked`=0 → FIN with err 1.
  - steps=0 → FIN with err 0.
  - Otherwise → PULSE.
- PULSE: `phase_en`=1 for exactly EN_CYCLES cycles, then go to WAIT_LO.
- WAIT_LO: wait for synchronised `phase_done`=0, then go to WAIT_HI.
- WAIT_HI: wait for synchronised `phase_done`=1. On seeing it:
  - `pos[ch]` ±1, modulo 2^POS_W (wraps silently).
  - `steps_done`+1.
  - If `steps_done`==steps, go to FIN with err 0; else go to PULSE.
- Timeout: a counter reloads on entry to WAIT_LO and to WAIT_HI. Reaching TIMEOUT in either state → FIN with err 2. The position is not updated for that step.
- Lock loss: synchronised `locked`=0 in PULSE, WAIT_LO or WAIT_HI → FIN with err 1.
  - `phase_en` drops in the same cycle.
  - The in-flight step is not counted.
- FIN: `done`=1 for one cycle, then IDLE.
- `updn` and `cntsel` hold their latched values from accept through FIN. They hold in IDLE until the next accept.
- `pos_clr` in IDLE clears every lane next cycle. If `pos_clr` and a command accept occur in the same cycle, both take effect.

## Timing
- Accept at cycle 0 → CHECK at cycle 1 → `phase_en` high at cycles 2..EN_CYCLES+1.
- Synchroniser latency on `locked`/`phase_done` is 2 cycles. A `phase_done` pulse shorter than 1 refclk period may be missed, and that is covered by the timeout.
- The `pos` update and `steps_done` increment are visible the cycle after WAIT_HI sees `phase_done`=1.
- Error paths from CHECK: `done` asserts at cycle 2.
- `cmd_ready` is low from the cycle after accept until the cycle after `done`.
- Asynchronous `rst` mid-operation:
  - `phase_en` drops immediately.
  - Positions clear.
  - No `done` is issued.

## Test plan
- NUM_CH=4, locked=1, model PLL drops `phase_done` 1 cycle after `phase_en` and raises it 3 cycles later. Command ch=2, dir=1, steps=5 → 5 `phase_en` pulses of 2 cycles each; pos[2]=+5; `done` with err 0; `steps_done`=5; `cntsel`=2 and `updn`=1 throughout.
- ch=1, dir=0, steps=3, starting from pos[1]=0 → pos[1]=0xFFFD. Then pos_clr → all lanes 0.
- steps=0 → `done` at cycle 2, err 0, no `phase_en`. ch=7 → err 3, no `phase_en`.
- Model never raises `phase_done`, steps=4 → after TIMEOUT cycles in WAIT_HI, `done` with err 2, `steps_done`=0, pos unchanged.
- Drop `locked` during step 3 of 6 → `phase_en` low, err 1, `steps_done`=2, pos=+2. With locked=0 at accept → err 1 at cycle 2.
- Assert `rst` in WAIT_HI → all outputs at reset values; a new command is accepted after `rst` deasserts.
